// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//
// Byte queue that sits in front of a UART transmitter. Bytes pushed on
// wr_en are kept in a circular buffer. A small launch FSM hands them to the
// transmitter one at a time. Each hand-off is a one-cycle start pulse with
// the byte on tx_data. The FSM then waits for the transmitter to finish the
// frame before it launches the next byte.
//
// Ports
//   clk       in   single clock, all state updates on its rising edge
//   reset     in   synchronous active-high reset
//   wr_en     in   push request
//   wr_data   in   byte to enqueue
//   full      out  queue holds DEPTH bytes
//   empty     out  queue holds no bytes
//   count     out  number of bytes held, 0..DEPTH
//   overflow  out  one-cycle pulse when a push was dropped because of full
//   tx_busy   in   transmitter busy flag
//   tx_done   in   transmitter one-cycle frame-complete pulse
//   start     out  one-cycle launch pulse to the transmitter
//   tx_data   out  byte for the transmitter, held from one pop to the next
//
// Parameters
//   DEPTH     queue entries, power of two in 2..256
//   CW        count width, derived from DEPTH; leave at its default
// ---------------------------------------------------------------------------
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic          start,
  output logic [7:0]    tx_data
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic          start_q, start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          push_s;
  logic          pop_s;

  // Push and pop decisions for the coming edge.
  // A push is judged against the registered full flag. A pop on the same
  // edge therefore never rescues a write into a full queue: that write is
  // dropped and reported as overflow.
  always_comb begin
    push_s = wr_en & ~full_q;
    pop_s  = (state_q == ST_IDLE) & ~empty_q & ~tx_busy;
  end

  // Next-state logic for the pointers, occupancy, flags and output byte.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    full_d     = full_q;
    empty_d    = empty_q;
    overflow_d = 1'b0;

    // The power-of-two depth lets the pointers wrap by plain overflow.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // tx_data only changes on a pop, so it stays stable while start is high.
    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      tx_data_d = tx_data_q;
    end

    // A simultaneous push and pop leaves the count unchanged.
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    // Flags are registered from the next count, so they match count_q.
    full_d     = (count_d == COUNT_FULL);
    empty_d    = (count_d == COUNT_ZERO);
    overflow_d = wr_en & full_q;
  end

  // Launch FSM next-state logic. start is raised only on the IDLE pop.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_LAUNCH;
          start_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          start_d = 1'b0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A very short frame can report done before busy is ever seen.
        if (tx_done) begin
          state_d = ST_IDLE;
        end else if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers. Reset overrides any push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= COUNT_ZERO;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      start_q    <= start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Byte storage. It is not cleared by reset because the pointers already
  // mark every entry invalid. A push is still blocked during reset.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign start    = start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_busy;
  logic          tx_done;
  logic          start;
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .start    (start),
    .tx_data  (tx_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: byte list held, launcher readiness, expected outputs.
  logic [7:0] mq[$];        // bytes held by the queue
  logic [7:0] sb_q[$];      // scoreboard: accepted bytes awaiting launch
  int         phase = 0;    // 0 ready, 1 just launched, 2 await busy/done, 3 await done
  logic       exp_ovf   = 1'b0;
  logic       exp_start = 1'b0;
  logic [7:0] exp_tx    = 8'h00;
  int         start_seen = 0;

  // Transmitter model state.
  logic tx_auto  = 1'b0;
  logic pend     = 1'b0;
  int   busy_cnt = 0;
  int   len_lo   = 1;
  int   len_hi   = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the queue's rules, applied to the sampled inputs.
  task automatic model_step();
    logic was_full;
    logic do_pop;
    if (reset === 1'b1) begin
      mq.delete();
      sb_q.delete();
      phase     = 0;
      exp_ovf   = 1'b0;
      exp_start = 1'b0;
      exp_tx    = 8'h00;
    end else begin
      was_full  = (mq.size() == DEPTH);
      do_pop    = (phase == 0) && (mq.size() > 0) && (tx_busy === 1'b0);
      exp_ovf   = (wr_en === 1'b1) && was_full;
      exp_start = do_pop;
      if (do_pop) exp_tx = mq.pop_front();
      if ((wr_en === 1'b1) && !was_full) begin
        mq.push_back(wr_data);
        sb_q.push_back(wr_data);
      end
      case (phase)
        0: if (do_pop) phase = 1;
        1: phase = 2;
        2: if (tx_done === 1'b1) phase = 0; else if (tx_busy === 1'b1) phase = 3;
        3: if (tx_done === 1'b1) phase = 0;
        default: phase = 0;
      endcase
    end
  endtask

  // Monitor: step the model on each edge, compare just after it.
  initial begin
    logic [7:0] want;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("count",    count,    mq.size());
      chk("full",     full,     mq.size() == DEPTH);
      chk("empty",    empty,    mq.size() == 0);
      chk("overflow", overflow, exp_ovf);
      chk("start",    start,    exp_start);
      chk("tx_data",  tx_data,  exp_tx);
      if (start === 1'b1) begin
        start_seen++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_order at %0t: start with tx_data %0h but no byte expected", $time, tx_data);
        end else begin
          want = sb_q.pop_front();
          chk("sb_order", tx_data, want);
        end
      end
    end
  end

  // Transmitter: busy one cycle after start, done pulse when the frame ends.
  task automatic tx_step();
    tx_done = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
    end else if (pend) begin
      pend     = 1'b0;
      tx_busy  = 1'b1;
      busy_cnt = $urandom_range(len_hi, len_lo);
    end
    if (start === 1'b1) pend = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (tx_auto) tx_step();
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((mq.size() != 0 || phase != 0 || tx_busy || pend || busy_cnt != 0) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_timeout at %0t: count %0d not drained within %0d cycles", name, $time, count, n);
    end
  endtask

  initial begin
    int s0;
    int n;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_busy = 1'b0;
    tx_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single byte with the transmitter idle, then a manual done.
    s0 = start_seen;
    push(8'hA5);
    repeat (4) tick();
    chk("single_start_cnt", start_seen - s0, 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();

    // Fill to full with the transmitter busy, then one extra write.
    tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    push(8'h11);
    tick();
    chk("full_count", count, 16);

    // Full queue: a write on the same edge as a pop is dropped.
    tx_busy = 1'b0;
    push(8'h99);
    tx_busy = 1'b1;
    tick();
    chk("full_pop_count", count, 15);
    tick();
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Drain the rest through the transmitter model.
    tx_busy = 1'b0;
    tx_auto = 1'b1;
    drain("drain_full");

    // Three bytes through the transmitter model.
    s0 = start_seen;
    push(8'h55);
    push(8'hAA);
    push(8'h0F);
    drain("three_bytes");
    chk("three_start_cnt", start_seen - s0, 3);

    // 40 random bytes with random gaps, pointers wrap.
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(3, 0)) tick();
    end
    drain("wrap");

    // Reset while waiting for done, with 5 bytes queued.
    len_lo = 4;
    len_hi = 6;
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    n = 0;
    while (phase != 3 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_done_timeout at %0t: launcher never reached waiting-for-done", $time);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_txdata", tx_data, 8'h00);
    s0 = start_seen;
    repeat (20) tick();
    chk("no_start_after_reset", start_seen - s0, 0);
    push(8'h3C);
    drain("after_reset");
    chk("after_reset_start_cnt", start_seen - s0, 1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter: DEPTH, 16, queue entries; SHALL be a power of two, 2 to 256.
REQ-002 Parameter: CW, $clog2(DEPTH)+1, width of count; derived, SHALL NOT be overridden.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: wr_en  in  1  push request, sampled each clk edge.
REQ-006 Port: wr_data  in  8  byte to enqueue.
REQ-007 Port: full  out  1  count == DEPTH.
REQ-008 Port: empty  out  1  count == 0.
REQ-009 Port: count  out  CW  bytes held, 0..DEPTH.
REQ-010 Port: overflow  out  1  one-cycle pulse, write dropped.
REQ-011 Port: tx_busy  in  1  transmitter busy flag.
REQ-012 Port: tx_done  in  1  transmitter one-cycle frame-complete pulse.
REQ-013 Port: start  out  1  one-cycle launch pulse to the transmitter.
REQ-014 Port: tx_data  out  8  byte to the transmitter; SHALL be stable whenever start is high.

Function
REQ-015 Storage SHALL be a circular buffer with write and read pointers of $clog2(DEPTH) bits; pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 wr_en with full==0 SHALL store wr_data at the write pointer, advance the write pointer and increment count at the same edge.
REQ-017 wr_en with full==1 SHALL be dropped, leave storage, pointers and count unchanged, and pulse overflow high for exactly one cycle; this SHALL hold even if a pop occurs on the same edge.
REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged and advance both pointers.
REQ-019 full, empty and count SHALL be registered-state derived: valid the cycle after the edge that changed them.
REQ-020 The launch FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE: if empty==0 and tx_busy==0, the FSM SHALL pop: load tx_data from the read pointer, advance the read pointer, decrement count, set start=1, and go to LAUNCH. Otherwise it SHALL remain in IDLE.
REQ-022 LAUNCH: start SHALL return to 0 at the next edge (exactly one cycle high), and the FSM SHALL go to WAIT_BUSY.
REQ-023 WAIT_BUSY: tx_busy==1 SHALL move the FSM to WAIT_DONE; tx_done==1 seen here SHALL move it directly to IDLE.
REQ-024 WAIT_DONE: tx_done==1 SHALL move the FSM to IDLE; all other inputs SHALL be ignored.
REQ-025 tx_data SHALL change only on a pop and SHALL hold its value from the pop until the next pop.
REQ-026 Latency: a write accepted at edge k into an empty queue with the FSM in IDLE and tx_busy==0 SHALL produce start==1 during the cycle after edge k+1.
REQ-027 Back-to-back: with the queue non-empty, the next start SHALL assert the cycle after the first IDLE cycle in which tx_busy==0, following tx_done.
REQ-028 The block SHALL never assert start while tx_busy==1 or while the FSM is outside IDLE.

Reset
REQ-029 reset==1 at an edge SHALL set both pointers to 0, count=0, full=0, empty=1, overflow=0, start=0, tx_data=8'h00, and the FSM to IDLE; storage contents need not be cleared.
REQ-030 Reset asserted mid-frame SHALL discard all queued bytes and any pending wait; after release, the FSM SHALL launch only on new writes with tx_busy==0.
REQ-031 Reset SHALL take priority over wr_en and pop in the same cycle.

Verification
REQ-032 Reset, then write 8'hA5 once with tx_busy=0: start is high for 1 cycle, 2 edges after the write; tx_data=8'hA5; count goes 1 then 0.
REQ-033 Write 8'h01..8'h10 (16 bytes) with tx_busy held 1: full=1, count=16; a 17th write (8'h11) pulses overflow for 1 cycle and count stays 16.
REQ-034 Connect to the transmitter model (busy one cycle after start, done pulse at frame end) and queue 8'h55, 8'hAA, 8'h0F: exactly three start pulses, in order, each in the cycle after the first IDLE cycle with tx_busy==0 following tx_done; no start while busy.
REQ-035 Pointer wrap: push and pop 40 bytes through DEPTH=16: output order matches input order and count never exceeds 16.
REQ-036 With the queue full, write on the same edge as a pop: the write is dropped, overflow pulses, and count becomes 15.
REQ-037 Assert reset in WAIT_DONE with 5 bytes queued: next cycle count=0, empty=1, start=0, tx_data=8'h00; no start follows until a new write.
